// File: rtl/main_control.sv
// Multicycle MIPS main control unit: a Moore FSM sequencing fetch, decode,
// execute, memory and write-back, driving every datapath strobe and select.
module main_control #(
  parameter logic [5:0] OP_R   = 6'h00,
  parameter logic [5:0] OP_LW  = 6'h23,
  parameter logic [5:0] OP_SW  = 6'h2B,
  parameter logic [5:0] OP_BEQ = 6'h04,
  parameter logic [5:0] OP_J   = 6'h02
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       LoadA,
  output logic       LoadB,
  output logic       LoadALUOut,
  output logic       LoadMDR,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ULAOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state_out
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_RESET      = 4'd0,
    S_FETCH      = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_DECODE     = 4'd3,
    S_MEM_ADDR   = 4'd4,
    S_LW_READ    = 4'd5,
    S_LW_WAIT    = 4'd6,
    S_LW_WB      = 4'd7,
    S_SW_WRITE   = 4'd8,
    S_R_EXEC     = 4'd9,
    S_R_WB       = 4'd10,
    S_BEQ        = 4'd11,
    S_JUMP       = 4'd12,
    S_ILLEGAL    = 4'd13
  } state_t;

  typedef struct packed {
    logic             pc_write;
    logic             pc_write_cond;
    logic             ior_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic             load_a;
    logic             load_b;
    logic             load_alu_out;
    logic             load_mdr;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] ula_op;
    logic [SEL_W-1:0] pc_source;
    logic             illegal;
  } ctrl_t;

  state_t state;
  state_t next_state;
  logic   released;
  ctrl_t  ctrl;
  ctrl_t  ctrl_next;

  // Control word for a given state; unlisted fields and unused codes stay 0.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.pc_write  = 1'b1;
      end
      S_FETCH_WAIT: begin
        c.mem_read = 1'b1;
        c.ir_write = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b    = 2'b11;
        c.load_a       = 1'b1;
        c.load_b       = 1'b1;
        c.load_alu_out = 1'b1;
      end
      S_MEM_ADDR: begin
        c.alu_src_a    = 1'b1;
        c.alu_src_b    = 2'b10;
        c.load_alu_out = 1'b1;
      end
      S_LW_READ: begin
        c.mem_read = 1'b1;
        c.ior_d    = 1'b1;
      end
      S_LW_WAIT: begin
        c.mem_read = 1'b1;
        c.ior_d    = 1'b1;
        c.load_mdr = 1'b1;
      end
      S_LW_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_SW_WRITE: begin
        c.mem_write = 1'b1;
        c.ior_d     = 1'b1;
      end
      S_R_EXEC: begin
        c.alu_src_a    = 1'b1;
        c.ula_op       = 2'b10;
        c.load_alu_out = 1'b1;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a     = 1'b1;
        c.ula_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_ILLEGAL: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic; outputs are registered alongside the state so they
  // always equal the decode of the state register.
  always_comb begin
    next_state = S_FETCH;
    ctrl_next  = '0;
    case (state)
      S_RESET:      next_state = released ? S_FETCH : S_RESET;
      S_FETCH:      next_state = S_FETCH_WAIT;
      S_FETCH_WAIT: next_state = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_R)                         next_state = S_R_EXEC;
        else if (opcode == OP_LW || opcode == OP_SW) next_state = S_MEM_ADDR;
        else if (opcode == OP_BEQ)                  next_state = S_BEQ;
        else if (opcode == OP_J)                    next_state = S_JUMP;
        else                                        next_state = S_ILLEGAL;
      end
      S_MEM_ADDR:   next_state = (opcode == OP_LW) ? S_LW_READ : S_SW_WRITE;
      S_LW_READ:    next_state = S_LW_WAIT;
      S_LW_WAIT:    next_state = S_LW_WB;
      S_R_EXEC:     next_state = S_R_WB;
      default:      next_state = S_FETCH;
    endcase
    ctrl_next = decode(next_state);
  end

  // The release flag holds RESET for one full cycle after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_RESET;
      released <= 1'b0;
      ctrl     <= '0;
    end else begin
      state    <= next_state;
      released <= 1'b1;
      ctrl     <= ctrl_next;
    end
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.ior_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign LoadA       = ctrl.load_a;
  assign LoadB       = ctrl.load_b;
  assign LoadALUOut  = ctrl.load_alu_out;
  assign LoadMDR     = ctrl.load_mdr;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ULAOp       = ctrl.ula_op;
  assign PCSource    = ctrl.pc_source;
  assign illegal_op  = ctrl.illegal;
  assign state_out   = state;

endmodule

// File: tb/tb_main_control.sv
// Randomized bench for main_control: instruction-level state-sequence tables
// and a per-state output table are compared against the DUT every cycle.
module tb_main_control;

  logic       clk;
  logic       reset_n;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, LoadA, LoadB, LoadALUOut, LoadMDR;
  logic [1:0] ALUSrcB, ULAOp, PCSource;
  logic       illegal_op;
  logic [3:0] state_out;

  int n_vec = 0;
  int n_bad = 0;

  main_control dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .LoadA(LoadA), .LoadB(LoadB),
    .LoadALUOut(LoadALUOut), .LoadMDR(LoadMDR), .ALUSrcB(ALUSrcB),
    .ULAOp(ULAOp), .PCSource(PCSource), .illegal_op(illegal_op),
    .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, load_a, load_b;
    logic       load_alu_out, load_mdr;
    logic [1:0] alu_src_b, ula_op, pc_source;
    logic       illegal;
  } outs_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic outs_t observed();
    outs_t o;
    o = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
          RegDst, RegWrite, ALUSrcA, LoadA, LoadB, LoadALUOut, LoadMDR,
          ALUSrcB, ULAOp, PCSource, illegal_op};
    return o;
  endfunction

  // Output table straight from the state descriptions.
  function automatic outs_t expected(input int s);
    outs_t o;
    o = '0;
    case (s)
      1:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.pc_write = 1; end
      2:  begin o.mem_read = 1; o.ir_write = 1; end
      3:  begin o.alu_src_b = 2'b11; o.load_a = 1; o.load_b = 1; o.load_alu_out = 1; end
      4:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.load_alu_out = 1; end
      5:  begin o.mem_read = 1; o.ior_d = 1; end
      6:  begin o.mem_read = 1; o.ior_d = 1; o.load_mdr = 1; end
      7:  begin o.reg_write = 1; o.mem_to_reg = 1; end
      8:  begin o.mem_write = 1; o.ior_d = 1; end
      9:  begin o.alu_src_a = 1; o.ula_op = 2'b10; o.load_alu_out = 1; end
      10: begin o.reg_write = 1; o.reg_dst = 1; end
      11: begin o.alu_src_a = 1; o.ula_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; end
      12: begin o.pc_write = 1; o.pc_source = 2'b10; end
      13: o.illegal = 1;
      default: o = '0;
    endcase
    return o;
  endfunction

  int    cur;
  int    seq[$];
  outs_t obs;

  // One clock: present opcode (real only where it matters), then check arrival state.
  task automatic step(input int nxt, input logic [5:0] op);
    opcode = (cur == 3 || cur == 4) ? op : 6'($urandom);
    @(posedge clk);
    #1;
    obs = observed();
    check("state", 32'(state_out), 32'(nxt));
    check("outputs", 32'(obs), 32'(expected(nxt)));
    if (MemRead && MemWrite) check("mem_excl", 32'(1), 32'(0));
    if (PCWrite && PCWriteCond) check("pc_excl", 32'(1), 32'(0));
    cur = nxt;
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02;
  endfunction

  // Run one instruction starting in FETCH, ending back in FETCH.
  task automatic run_instr(input logic [5:0] op);
    case (op)
      6'h00:   seq = '{1, 2, 3, 9, 10};
      6'h23:   seq = '{1, 2, 3, 4, 5, 6, 7};
      6'h2B:   seq = '{1, 2, 3, 4, 8};
      6'h04:   seq = '{1, 2, 3, 11};
      6'h02:   seq = '{1, 2, 3, 12};
      default: seq = '{1, 2, 3, 13};
    endcase
    for (int i = 1; i < seq.size(); i++) step(seq[i], op);
    step(1, op);
  endtask

  logic [5:0] rop;

  initial begin
    reset_n = 1'b0;
    opcode  = 6'($urandom);
    cur     = 0;
    #1;
    obs = observed();
    check("rst_state_async", 32'(state_out), 32'(0));
    check("rst_outs_async", 32'(obs), 32'(0));
    for (int i = 0; i < 3; i++) begin
      opcode = 6'($urandom);
      @(posedge clk);
      #1;
      obs = observed();
      check("rst_state", 32'(state_out), 32'(0));
      check("rst_outs", 32'(obs), 32'(0));
    end
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 6'h00);
    step(1, 6'h00);

    // Directed pass over every instruction class, including LW then SW.
    run_instr(6'h00);
    run_instr(6'h23);
    run_instr(6'h2B);
    run_instr(6'h04);
    run_instr(6'h02);
    run_instr(6'h3F);

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 5))
        0: rop = 6'h00;
        1: rop = 6'h23;
        2: rop = 6'h2B;
        3: rop = 6'h04;
        4: rop = 6'h02;
        default: begin
          rop = 6'($urandom);
          while (legal(rop)) rop = 6'($urandom);
        end
      endcase
      run_instr(rop);
    end

    // Asynchronous reset in the middle of an LW, between clock edges.
    step(2, 6'h23);
    step(3, 6'h23);
    step(4, 6'h23);
    step(5, 6'h23);
    check("pre_rst_memread", 32'(MemRead), 32'(1));
    #2;
    reset_n = 1'b0;
    #1;
    obs = observed();
    check("mid_rst_state", 32'(state_out), 32'(0));
    check("mid_rst_memread", 32'(MemRead), 32'(0));
    check("mid_rst_outs", 32'(obs), 32'(0));
    cur = 0;
    @(posedge clk);
    #1;
    check("mid_rst_hold", 32'(state_out), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 6'h00);
    step(1, 6'h00);
    run_instr(6'h23);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
